// File: rtl/mux16_arbiter.sv
// Round-robin arbiter that shares one 16-bit output path between N requesters.
// A grant lasts for one burst of words, with a valid/ready handshake to a single consumer.
module mux16_arbiter #(
  parameter int N         = 4,
  parameter int SELW      = 2,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      req,
  input  logic [N-1:0]      last,
  input  logic [16*N-1:0]   data_in,
  input  logic              out_ready,
  output logic [15:0]       out,
  output logic              out_valid,
  output logic [N-1:0]      grant,
  output logic [SELW-1:0]   sel,
  output logic              busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_reg, state_next;
  logic [SELW-1:0] ptr_reg, ptr_next;
  logic [SELW-1:0] sel_reg, sel_next;
  logic [N-1:0]    grant_reg, grant_next;
  logic [7:0]      count_reg, count_next;
  logic [SELW-1:0] pick, sel_inc;
  logic            found, xfer, burst_done;
  logic [15:0]     slice [N];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_slice
      assign slice[gi] = data_in[16*gi +: 16];
    end
  endgenerate

  // First requester at or after ptr, wrapping modulo N.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[(int'(ptr_reg) + k) % N]) begin
        found = 1'b1;
        pick  = SELW'((int'(ptr_reg) + k) % N);
      end
    end
  end

  assign sel_inc    = (sel_reg == SELW'(N - 1)) ? '0 : sel_reg + 1'b1;
  assign busy       = (state_reg == GRANT);
  assign out_valid  = busy & req[sel_reg];
  assign out        = busy ? slice[sel_reg] : 16'h0000;
  assign grant      = grant_reg;
  assign sel        = sel_reg;
  assign xfer       = out_valid & out_ready;
  assign burst_done = last[sel_reg] | (({1'b0, count_reg} + 9'd1) == 9'(MAX_BURST));

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    sel_next   = sel_reg;
    grant_next = grant_reg;
    count_next = count_reg;
    case (state_reg)
      IDLE: begin
        if (found) begin
          grant_next       = '0;
          grant_next[pick] = 1'b1;
          sel_next         = pick;
          count_next       = 8'd0;
          state_next       = GRANT;
        end
      end
      GRANT: begin
        // A stall (valid without ready) holds everything; only a missing request abandons.
        if (xfer) begin
          count_next = count_reg + 8'd1;
          if (burst_done) begin
            grant_next = '0;
            ptr_next   = sel_inc;
            state_next = IDLE;
          end
        end else if (!req[sel_reg]) begin
          grant_next = '0;
          ptr_next   = sel_inc;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      sel_reg   <= '0;
      grant_reg <= '0;
      count_reg <= 8'd0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      sel_reg   <= sel_next;
      grant_reg <= grant_next;
      count_reg <= count_next;
    end
  end

endmodule

// File: tb/tb_mux16_arbiter.sv
// Directed bench for mux16_arbiter (N=4, MAX_BURST=8): reset, round robin,
// burst cap, backpressure, withdrawal and asynchronous reset.
module tb_mux16_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req, last;
  logic [63:0] data_in;
  logic        out_ready;
  logic [15:0] out;
  logic        out_valid;
  logic [3:0]  grant;
  logic [1:0]  sel;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  mux16_arbiter #(.N(4), .SELW(2), .MAX_BURST(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .last(last), .data_in(data_in),
    .out_ready(out_ready), .out(out), .out_valid(out_valid), .grant(grant),
    .sel(sel), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    req = '0; last = '0; out_ready = 1'b0;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    req = '0; last = '0; out_ready = 1'b0; data_in = '0;
    rst_n = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (grant !== 4'b0 || sel !== 2'd0 || busy !== 1'b0 || out_valid !== 1'b0 || out !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_state: grant=%b sel=%0d busy=%b valid=%b out=%h, want 0000/0/0/0/0000",
               grant, sel, busy, out_valid, out);
    end
    #3;
    rst_n = 1'b1;
    step();
    $display("test_reset: done");
  endtask

  task automatic test_single();
    do_reset();
    data_in = 64'h0000_0000_A5A5_0000;
    req = 4'b0010; last = 4'b0010; out_ready = 1'b1;
    #1;
    n_checks++;
    if (grant !== 4'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle: grant=%b valid=%b, want 0000/0", grant, out_valid);
    end
    step();
    n_checks++;
    if (grant !== 4'b0010 || sel !== 2'd1 || out !== 16'hA5A5 || out_valid !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_grant: grant=%b sel=%0d out=%h valid=%b busy=%b, want 0010/1/a5a5/1/1",
               grant, sel, out, out_valid, busy);
    end
    step();
    n_checks++;
    if (grant !== 4'b0 || busy !== 1'b0 || out !== 16'h0) begin
      n_fail++;
      $display("FAIL single_release: grant=%b busy=%b out=%h, want 0000/0/0000", grant, busy, out);
    end
    step();
    n_checks++;
    if (grant !== 4'b0010) begin
      n_fail++;
      $display("FAIL single_regrant: grant=%b, want 0010", grant);
    end
    req = '0;
    step();
    $display("test_single: done");
  endtask

  task automatic test_round_robin();
    do_reset();
    data_in = 64'h1003_1002_1001_1000;
    req = 4'b1111; last = 4'b1111; out_ready = 1'b1;
    for (int g = 0; g < 5; g++) begin
      step();
      n_checks++;
      if (grant !== (4'b0001 << (g % 4)) || out !== (16'h1000 + 16'(g % 4))) begin
        n_fail++;
        $display("FAIL rr_grant%0d: grant=%b out=%h, want %b/%h", g, grant, out,
                 4'b0001 << (g % 4), 16'h1000 + 16'(g % 4));
      end
      step();
      n_checks++;
      if (grant !== 4'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL rr_gap%0d: grant=%b busy=%b, want 0000/0", g, grant, busy);
      end
    end
    $display("test_round_robin: done");
  endtask

  task automatic test_burst_cap();
    int xfers = 0;
    do_reset();
    data_in = 64'h0000_2222_0000_0000;
    req = 4'b0100; last = 4'b0000; out_ready = 1'b1;
    step();
    n_checks++;
    if (grant !== 4'b0100 || sel !== 2'd2) begin
      n_fail++;
      $display("FAIL cap_grant: grant=%b sel=%0d, want 0100/2", grant, sel);
    end
    for (int c = 0; c < 20 && busy; c++) begin
      if (out_valid && out_ready) xfers++;
      step();
    end
    n_checks++;
    if (xfers !== 8 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL cap_count: transfers=%0d busy=%b, want 8/0", xfers, busy);
    end
    // ptr is now 3: scan 3,0 -> requester 0 wins over 1 and 2.
    req = 4'b0111;
    step();
    n_checks++;
    if (grant !== 4'b0001) begin
      n_fail++;
      $display("FAIL cap_ptr: grant=%b, want 0001", grant);
    end
    $display("test_burst_cap: transfers=%0d", xfers);
  endtask

  task automatic test_backpressure();
    int xfers = 0;
    do_reset();
    data_in = 64'h0000_0000_0000_BEEF;
    req = 4'b0001; last = 4'b0000; out_ready = 1'b0;
    step();
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (out !== 16'hBEEF || sel !== 2'd0 || grant !== 4'b0001 || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL stall%0d: out=%h sel=%0d grant=%b valid=%b, want beef/0/0001/1",
                 c, out, sel, grant, out_valid);
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    for (int c = 0; c < 20 && busy; c++) begin
      if (out_valid && out_ready) xfers++;
      step();
    end
    n_checks++;
    if (xfers !== 8 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_count: transfers=%0d busy=%b, want 8/0", xfers, busy);
    end
    $display("test_backpressure: transfers=%0d", xfers);
  endtask

  task automatic test_withdrawal();
    do_reset();
    data_in = 64'h0000_0000_3333_4444;
    req = 4'b0001; last = 4'b0000; out_ready = 1'b1;
    step();
    req = 4'b0000;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL wd_valid: valid=%b busy=%b, want 0/1", out_valid, busy);
    end
    step();
    n_checks++;
    if (grant !== 4'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wd_release: grant=%b busy=%b, want 0000/0", grant, busy);
    end
    req = 4'b0011;
    step();
    n_checks++;
    if (grant !== 4'b0010 || out !== 16'h3333) begin
      n_fail++;
      $display("FAIL wd_ptr: grant=%b out=%h, want 0010/3333", grant, out);
    end
    $display("test_withdrawal: done");
  endtask

  task automatic test_async_reset();
    do_reset();
    data_in = 64'h4444_3333_2222_1111;
    req = 4'b1111; last = 4'b1111; out_ready = 1'b1;
    step();
    step();
    step();
    out_ready = 1'b0;
    #1;
    n_checks++;
    if (grant !== 4'b0010 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL ar_setup: grant=%b valid=%b, want 0010/1", grant, out_valid);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (grant !== 4'b0 || out_valid !== 1'b0 || busy !== 1'b0 || out !== 16'h0) begin
      n_fail++;
      $display("FAIL ar_drop: grant=%b valid=%b busy=%b out=%h, want 0000/0/0/0000",
               grant, out_valid, busy, out);
    end
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    n_checks++;
    if (grant !== 4'b0001 || out !== 16'h1111) begin
      n_fail++;
      $display("FAIL ar_regrant: grant=%b out=%h, want 0001/1111", grant, out);
    end
    $display("test_async_reset: done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_burst_cap();
    test_backpressure();
    test_withdrawal();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
